// File: rtl/uart_protocol_rx.sv
// Host-to-FPGA command frame parser: HEADER, PAYLOAD_LEN payload bytes, CRC8, TAIL.
// Validates each frame and publishes the payload of good frames on rev_data.
module uart_protocol_rx #(
    parameter logic [7:0]  HEADER         = 8'h80,
    parameter logic [7:0]  TAIL           = 8'h55,
    parameter int unsigned PAYLOAD_LEN    = 11,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic                     clk_50M,
    input  logic                     rst,
    input  logic                     rx_byte_valid,
    input  logic [7:0]               rx_byte,
    output logic [8*PAYLOAD_LEN-1:0] rev_data,
    output logic                     recv_done,
    output logic                     crc_err,
    output logic                     frame_err,
    output logic                     busy,
    output logic [15:0]              good_cnt,
    output logic [15:0]              err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_CHECK,
        ST_TAIL
    } state_t;

    localparam logic [3:0]  LAST_IDX = 4'(PAYLOAD_LEN - 1);
    localparam logic [15:0] TMO_LAST = TIMEOUT_CYCLES - 16'd1;

    state_t                     state;
    logic [3:0]                 idx;
    logic [7:0]                 crc;
    logic                       crc_ok;
    logic [15:0]                tmo_cnt;
    logic [8*PAYLOAD_LEN-1:0]   shadow;

    logic tail_byte;
    logic tmo_hit;
    logic good_ev;
    logic crc_ev;
    logic frm_ev;

    // CRC8, poly 0x07, MSB-first, no reflection.
    function automatic logic [7:0] crc8_next(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int unsigned i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction

    // A byte arriving on the would-be timeout cycle takes precedence.
    always_comb begin
        tail_byte = 1'b0;
        tmo_hit   = 1'b0;
        good_ev   = 1'b0;
        crc_ev    = 1'b0;
        frm_ev    = 1'b0;
        tail_byte = (state == ST_TAIL) && rx_byte_valid;
        tmo_hit   = (state != ST_IDLE) && !rx_byte_valid && (tmo_cnt == TMO_LAST);
        good_ev   = tail_byte && (rx_byte == TAIL) && crc_ok;
        crc_ev    = tail_byte && (rx_byte == TAIL) && !crc_ok;
        frm_ev    = (tail_byte && (rx_byte != TAIL)) || tmo_hit;
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            crc       <= '0;
            crc_ok    <= 1'b0;
            tmo_cnt   <= '0;
            shadow    <= '0;
            rev_data  <= '0;
            recv_done <= 1'b0;
            crc_err   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            good_cnt  <= '0;
            err_cnt   <= '0;
        end else begin
            recv_done <= good_ev;
            crc_err   <= crc_ev;
            frame_err <= frm_ev;

            if (good_ev) begin
                rev_data <= shadow;
                good_cnt <= good_cnt + 16'd1;
            end
            if ((crc_ev || frm_ev) && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end

            if (state != ST_IDLE) begin
                tmo_cnt <= rx_byte_valid ? 16'd0 : tmo_cnt + 16'd1;
            end

            if (tmo_hit) begin
                state   <= ST_IDLE;
                busy    <= 1'b0;
                tmo_cnt <= '0;
            end else if (rx_byte_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_byte == HEADER) begin
                            state   <= ST_PAYLOAD;
                            busy    <= 1'b1;
                            idx     <= '0;
                            crc     <= '0;
                            tmo_cnt <= '0;
                        end
                    end
                    ST_PAYLOAD: begin
                        shadow[8*idx +: 8] <= rx_byte;
                        crc                <= crc8_next(crc, rx_byte);
                        if (idx == LAST_IDX) begin
                            state <= ST_CHECK;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                    ST_CHECK: begin
                        crc_ok <= (rx_byte == crc);
                        state  <= ST_TAIL;
                    end
                    ST_TAIL: begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        tmo_cnt <= '0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_protocol_rx.sv
// Scoreboard bench for uart_protocol_rx with PAYLOAD_LEN=9 and TIMEOUT_CYCLES=100.
module tb_uart_protocol_rx;

    localparam int unsigned PL = 9;
    localparam logic [2:0] K_GOOD = 3'b100;
    localparam logic [2:0] K_CRC  = 3'b010;
    localparam logic [2:0] K_FRM  = 3'b001;

    logic              clk_50M = 1'b0;
    logic              rst = 1'b0;
    logic              rx_byte_valid = 1'b0;
    logic [7:0]        rx_byte = 8'h00;
    logic [8*PL-1:0]   rev_data;
    logic              recv_done;
    logic              crc_err;
    logic              frame_err;
    logic              busy;
    logic [15:0]       good_cnt;
    logic [15:0]       err_cnt;

    typedef struct {
        logic [2:0]      kind;
        logic [8*PL-1:0] data;
    } exp_t;

    exp_t            sb[$];
    int              checks = 0;
    int              errors = 0;
    logic [8*PL-1:0] model_rev = '0;
    logic [15:0]     good_exp = '0;
    logic [15:0]     err_exp = '0;

    uart_protocol_rx #(
        .PAYLOAD_LEN(PL),
        .TIMEOUT_CYCLES(16'd100)
    ) dut (
        .clk_50M(clk_50M),
        .rst(rst),
        .rx_byte_valid(rx_byte_valid),
        .rx_byte(rx_byte),
        .rev_data(rev_data),
        .recv_done(recv_done),
        .crc_err(crc_err),
        .frame_err(frame_err),
        .busy(busy),
        .good_cnt(good_cnt),
        .err_cnt(err_cnt)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic check(input string name, input logic [8*PL-1:0] act, input logic [8*PL-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation.
    always @(negedge clk_50M) begin
        if (!rst && (recv_done || crc_err || frame_err)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got %b expected none", {recv_done, crc_err, frame_err});
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_kind", {69'd0, recv_done, crc_err, frame_err}, {69'd0, e.kind});
                check("rev_data", rev_data, e.data);
            end
        end
    end

    function automatic logic [7:0] ref_crc8(input logic [8*PL-1:0] p);
        logic [7:0] c;
        c = 8'h00;
        for (int k = 0; k < PL; k++) begin
            c = c ^ p[8*k +: 8];
            for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    task automatic expect_ev(input logic [2:0] k, input logic [8*PL-1:0] pl);
        if (k == K_GOOD) begin
            model_rev = pl;
            good_exp++;
        end else begin
            err_exp++;
        end
        sb.push_back('{kind: k, data: model_rev});
    endtask

    task automatic put_byte(input logic [7:0] b);
        @(negedge clk_50M);
        rx_byte_valid = 1'b1;
        rx_byte = b;
    endtask

    task automatic send_byte(input logic [7:0] b);
        put_byte(b);
        @(negedge clk_50M);
        rx_byte_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [8*PL-1:0] pl, input logic [7:0] c,
                              input logic [7:0] t, input logic [2:0] k);
        expect_ev(k, pl);
        send_byte(8'h80);
        for (int i = 0; i < PL; i++) send_byte(pl[8*i +: 8]);
        send_byte(c);
        send_byte(t);
    endtask

    // Bytes on consecutive cycles; caller drops valid afterwards.
    task automatic burst_frame(input logic [8*PL-1:0] pl, input logic [7:0] c);
        expect_ev(K_GOOD, pl);
        put_byte(8'h80);
        for (int i = 0; i < PL; i++) put_byte(pl[8*i +: 8]);
        put_byte(c);
        put_byte(8'h55);
    endtask

    task automatic do_reset();
        @(negedge clk_50M);
        rst = 1'b1;
        rx_byte_valid = 1'b0;
        repeat (2) @(negedge clk_50M);
        rst = 1'b0;
        model_rev = '0;
        good_exp = '0;
        err_exp = '0;
    endtask

    task automatic check_cnts(input string tag);
        check({tag, "_good_cnt"}, {56'd0, good_cnt}, {56'd0, good_exp});
        check({tag, "_err_cnt"}, {56'd0, err_cnt}, {56'd0, err_exp});
    endtask

    logic [8*PL-1:0] zeros = '0;
    logic [8*PL-1:0] ascii = 72'h39_38_37_36_35_34_33_32_31;
    logic [8*PL-1:0] marks = 72'h05_04_03_02_01_55_80_55_80;
    logic            quiet;

    initial begin
        do_reset();
        check("reset_rev_data", rev_data, '0);
        check("reset_pulses", {69'd0, recv_done, crc_err, frame_err}, '0);
        check("reset_busy", {71'd0, busy}, '0);
        check_cnts("reset");

        send_frame(zeros, 8'h00, 8'h55, K_GOOD);
        check_cnts("zeros");

        send_byte(8'h12);
        send_byte(8'h55);
        send_byte(8'h00);
        send_frame(ascii, 8'hF4, 8'h55, K_GOOD);
        check("ascii_byte0", {64'd0, rev_data[7:0]}, 72'h31);
        check("ascii_byte8", {64'd0, rev_data[71:64]}, 72'h39);

        send_frame(ascii, 8'hF5, 8'h55, K_CRC);
        check_cnts("crc_bad");

        send_frame(zeros, 8'h00, 8'hAA, K_FRM);
        send_frame(marks, ref_crc8(marks), 8'h55, K_GOOD);
        check("marks_verbatim", rev_data, marks);

        // Timeout: frame_err exactly 100 cycles after the last accepted byte.
        expect_ev(K_FRM, zeros);
        send_byte(8'h80);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        quiet = 1'b1;
        repeat (99) begin
            @(negedge clk_50M);
            if (frame_err || !busy) quiet = 1'b0;
        end
        check("tmo_quiet_before", {71'd0, quiet}, 72'd1);
        @(negedge clk_50M);
        check("tmo_frame_err", {71'd0, frame_err}, 72'd1);
        check("tmo_busy_drop", {71'd0, busy}, 72'd0);
        check_cnts("tmo");

        // Byte on the 100th cycle rescues the frame; then reset mid-frame.
        send_byte(8'h80);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        repeat (99) @(negedge clk_50M);
        rx_byte_valid = 1'b1;
        rx_byte = 8'h04;
        @(negedge clk_50M);
        rx_byte_valid = 1'b0;
        check("tmo_rescue_no_err", {71'd0, frame_err}, 72'd0);
        check("tmo_rescue_busy", {71'd0, busy}, 72'd1);
        send_byte(8'h05);
        do_reset();
        check_cnts("midrst");
        check("midrst_busy", {71'd0, busy}, 72'd0);
        check("midrst_rev_data", rev_data, '0);

        send_frame(ascii, 8'hF4, 8'h55, K_GOOD);
        check_cnts("after_rst");

        burst_frame(zeros, 8'h00);
        burst_frame(ascii, 8'hF4);
        @(negedge clk_50M);
        rx_byte_valid = 1'b0;
        repeat (5) @(negedge clk_50M);
        check_cnts("b2b");

        check("sb_empty", 72'(sb.size()), 72'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
